// File: rtl/taxi_baser_pkg.sv
// Definitions shared by the 10GBASE-R receive path: sync header codes and
// the block-lock state encoding.
package taxi_baser_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef enum logic [1:0] {
    TEST_SH   = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

endpackage

// File: rtl/taxi_baser_rx_block_lock.sv
// 10GBASE-R receive block lock: tests sync headers, requests bitslips until
// alignment is found and tracks lock loss over fixed header windows.
module taxi_baser_rx_block_lock #(
  parameter int HDR_W      = 2,
  parameter bit GBX_IF_EN  = 1'b0,
  parameter int SH_CNT_MAX = 64,
  parameter int SH_INV_MAX = 16,
  parameter int SLIP_WAIT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HDR_W-1:0] encoded_rx_hdr,
  input  logic             encoded_rx_hdr_valid,
  output logic             rx_block_lock,
  output logic             serdes_rx_bitslip,
  output logic             rx_sh_invalid,
  output logic [7:0]       rx_unlock_count
);

  // The SLIP_WAIT parameter shadows the state name, so the states are
  // imported individually and SLIP_WAIT is always package-qualified.
  import taxi_baser_pkg::lock_state_t;
  import taxi_baser_pkg::TEST_SH;
  import taxi_baser_pkg::LOCKED;

  localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W = $clog2(SH_INV_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0] INV_LAST  = INV_W'(SH_INV_MAX);
  localparam logic [7:0]       SLIP_LOAD = 8'(SLIP_WAIT);

  if (HDR_W != 2) begin : g_bad_hdr_w
    $fatal(1, "HDR_W must be 2");
  end
  if (SH_CNT_MAX < 4 || SH_CNT_MAX > 1024) begin : g_bad_cnt_max
    $fatal(1, "SH_CNT_MAX must be 4..1024");
  end
  if (SH_INV_MAX < 1 || SH_INV_MAX > SH_CNT_MAX) begin : g_bad_inv_max
    $fatal(1, "SH_INV_MAX must be 1..SH_CNT_MAX");
  end
  if (SLIP_WAIT < 1 || SLIP_WAIT > 255) begin : g_bad_slip_wait
    $fatal(1, "SLIP_WAIT must be 1..255");
  end

  lock_state_t      state_q, state_d;
  logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0] sh_inv_cnt_q, sh_inv_cnt_d;
  logic [7:0]       slip_cnt_q, slip_cnt_d;
  logic             block_lock_q, block_lock_d;
  logic             bitslip_q, bitslip_d;
  logic             sh_invalid_q, sh_invalid_d;
  logic [7:0]       unlock_count_q, unlock_count_d;

  logic             eval_slot;
  logic             hdr_ok;
  logic [CNT_W-1:0] sh_cnt_inc;
  logic [INV_W-1:0] sh_inv_cnt_inc;

  always_comb begin
    eval_slot      = !GBX_IF_EN || encoded_rx_hdr_valid;
    hdr_ok         = encoded_rx_hdr[1] ^ encoded_rx_hdr[0];
    sh_cnt_inc     = sh_cnt_q + CNT_W'(1);
    sh_inv_cnt_inc = sh_inv_cnt_q + INV_W'(!hdr_ok);

    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_inv_cnt_d   = sh_inv_cnt_q;
    slip_cnt_d     = slip_cnt_q;
    block_lock_d   = block_lock_q;
    bitslip_d      = 1'b0;
    sh_invalid_d   = 1'b0;
    unlock_count_d = unlock_count_q;

    if (eval_slot) begin
      sh_invalid_d = !hdr_ok;
      unique case (state_q)
        TEST_SH: begin
          if (!hdr_ok) begin
            bitslip_d    = 1'b1;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            slip_cnt_d   = SLIP_LOAD;
            state_d      = taxi_baser_pkg::SLIP_WAIT;
          end else if (sh_cnt_inc == CNT_LAST) begin
            block_lock_d = 1'b1;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            state_d      = LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_inc;
          end
        end
        taxi_baser_pkg::SLIP_WAIT: begin
          slip_cnt_d = slip_cnt_q - 8'd1;
          if (slip_cnt_q == 8'd1) begin
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            state_d      = TEST_SH;
          end
        end
        LOCKED: begin
          // Too many bad headers wins over the window boundary.
          if (sh_inv_cnt_inc == INV_LAST) begin
            block_lock_d = 1'b0;
            bitslip_d    = 1'b1;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            slip_cnt_d   = SLIP_LOAD;
            state_d      = taxi_baser_pkg::SLIP_WAIT;
            if (unlock_count_q != 8'hFF) begin
              unlock_count_d = unlock_count_q + 8'd1;
            end
          end else if (sh_cnt_inc == CNT_LAST) begin
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
          end else begin
            sh_cnt_d     = sh_cnt_inc;
            sh_inv_cnt_d = sh_inv_cnt_inc;
          end
        end
        default: begin
          state_d = TEST_SH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TEST_SH;
      sh_cnt_q       <= '0;
      sh_inv_cnt_q   <= '0;
      slip_cnt_q     <= '0;
      block_lock_q   <= 1'b0;
      bitslip_q      <= 1'b0;
      sh_invalid_q   <= 1'b0;
      unlock_count_q <= '0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_inv_cnt_q   <= sh_inv_cnt_d;
      slip_cnt_q     <= slip_cnt_d;
      block_lock_q   <= block_lock_d;
      bitslip_q      <= bitslip_d;
      sh_invalid_q   <= sh_invalid_d;
      unlock_count_q <= unlock_count_d;
    end
  end

  assign rx_block_lock     = block_lock_q;
  assign serdes_rx_bitslip = bitslip_q;
  assign rx_sh_invalid     = sh_invalid_q;
  assign rx_unlock_count   = unlock_count_q;

endmodule

// File: tb/tb_taxi_baser_rx_block_lock.sv
// Randomized bench for the block-lock stage: one instance evaluates every
// cycle, the other only header-qualified cycles, both against a slot model.
module tb_taxi_baser_rx_block_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hdr_a = 2'b01, hdr_b = 2'b01;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       lock_a, slip_a, inv_a, lock_b, slip_b, inv_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  taxi_baser_rx_block_lock #(.HDR_W(2), .GBX_IF_EN(1'b0), .SH_CNT_MAX(64),
                             .SH_INV_MAX(16), .SLIP_WAIT(16)) dut_a (
    .clk(clk), .rst(rst), .encoded_rx_hdr(hdr_a), .encoded_rx_hdr_valid(vld_a),
    .rx_block_lock(lock_a), .serdes_rx_bitslip(slip_a), .rx_sh_invalid(inv_a),
    .rx_unlock_count(cnt_a));

  taxi_baser_rx_block_lock #(.HDR_W(2), .GBX_IF_EN(1'b1), .SH_CNT_MAX(64),
                             .SH_INV_MAX(16), .SLIP_WAIT(16)) dut_b (
    .clk(clk), .rst(rst), .encoded_rx_hdr(hdr_b), .encoded_rx_hdr_valid(vld_b),
    .rx_block_lock(lock_b), .serdes_rx_bitslip(slip_b), .rx_sh_invalid(inv_b),
    .rx_unlock_count(cnt_b));

  // Reference: lock flag, slots left to ignore after a slip, good/bad tallies
  // within the current window, and the lifetime unlock count.
  typedef struct {
    bit lock;
    int ignore_left;
    int seen;
    int bad;
    int unlocks;
    bit slip;
    bit inv;
  } mdl_t;

  mdl_t ma, mb;

  task automatic mdl_reset(inout mdl_t m);
    m.lock = 0; m.ignore_left = 0; m.seen = 0; m.bad = 0;
    m.unlocks = 0; m.slip = 0; m.inv = 0;
  endtask

  task automatic mdl_step(inout mdl_t m, input logic [1:0] h, input bit ev);
    bit bad_hdr;
    m.slip = 0;
    m.inv  = 0;
    if (!ev) return;
    bad_hdr = (h == 2'b00) || (h == 2'b11);
    m.inv = bad_hdr;
    if (m.ignore_left > 0) begin
      m.ignore_left--;
      if (m.ignore_left == 0) begin m.seen = 0; m.bad = 0; end
    end else if (!m.lock) begin
      if (bad_hdr) begin
        m.slip = 1; m.seen = 0; m.bad = 0; m.ignore_left = 16;
      end else begin
        m.seen++;
        if (m.seen == 64) begin m.lock = 1; m.seen = 0; m.bad = 0; end
      end
    end else begin
      m.seen++;
      if (bad_hdr) m.bad++;
      if (m.bad == 16) begin
        m.lock = 0; m.slip = 1; m.seen = 0; m.bad = 0; m.ignore_left = 16;
        if (m.unlocks < 255) m.unlocks++;
      end else if (m.seen == 64) begin
        m.seen = 0; m.bad = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ok_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
  endfunction

  // One slot: drive at negedge, model the edge, compare just after it.
  task automatic tick(input logic [1:0] ha, input logic [1:0] hb, input logic vb);
    hdr_a = ha; vld_a = 1'($urandom_range(0, 1));
    hdr_b = hb; vld_b = vb;
    @(posedge clk);
    if (rst) begin
      mdl_reset(ma); mdl_reset(mb);
    end else begin
      mdl_step(ma, ha, 1'b1);
      mdl_step(mb, hb, vb);
    end
    #1;
    check("a_lock", lock_a, ma.lock);
    check("a_slip", slip_a, ma.slip);
    check("a_inv", inv_a, ma.inv);
    check("a_cnt", cnt_a, ma.unlocks);
    check("b_lock", lock_b, mb.lock);
    check("b_slip", slip_b, mb.slip);
    check("b_inv", inv_b, mb.inv);
    check("b_cnt", cnt_b, mb.unlocks);
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic [1:0] h;
    rst = 1'b1;
    h = ok_hdr();
    tick(h, h, 1'b1);
    rst = 1'b0;
  endtask

  task automatic run_valid(input int n);
    logic [1:0] h;
    for (int i = 0; i < n; i++) begin h = ok_hdr(); tick(h, h, 1'b1); end
  endtask

  task automatic unlock_loop();
    logic [1:0] h;
    run_valid(64);
    for (int i = 0; i < 16; i++) begin h = bad_hdr(); tick(h, h, 1'b1); end
    for (int i = 0; i < 16; i++) begin
      h = 2'($urandom_range(0, 3)); tick(h, h, 1'b1);
    end
  endtask

  initial begin
    int bad_pos[64];
    int tmp, j, nbad;
    logic [1:0] h;

    mdl_reset(ma); mdl_reset(mb);
    @(negedge clk);
    rst = 1'b1;
    tick(2'b00, 2'b00, 1'b1);
    tick(2'b11, 2'b11, 1'b1);
    check("rst_lock", lock_a, 0);
    check("rst_cnt", cnt_a, 0);
    rst = 1'b0;

    // Clean acquisition
    run_valid(63);
    check("acq_lock_63", lock_a, 0);
    run_valid(1);
    check("acq_lock_64", lock_a, 1);
    check("acq_lock_64_b", lock_b, 1);

    // Bad header in slot 10 while unlocked
    do_reset();
    run_valid(9);
    tick(2'b00, 2'b00, 1'b1);
    check("slot10_slip", slip_a, 1);
    check("slot10_inv", inv_a, 1);
    tick(2'b11, 2'b11, 1'b1);
    check("slot10_slip_1cyc", slip_a, 0);
    check("slot10_inv_again", inv_a, 1);
    for (int i = 0; i < 15; i++) begin
      tick(2'b11, 2'b11, 1'b1);
      check("wait_no_slip", slip_a, 0);
    end
    run_valid(63);
    check("relock_63", lock_a, 0);
    run_valid(1);
    check("relock_64", lock_a, 1);

    // Locked window with 15 bad headers, then one with 16
    for (int i = 0; i < 64; i++) bad_pos[i] = (i < 15) ? 1 : 0;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(0, i)); tmp = bad_pos[i]; bad_pos[i] = bad_pos[j]; bad_pos[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      h = bad_pos[i] ? bad_hdr() : ok_hdr(); tick(h, h, 1'b1);
    end
    check("win15_lock", lock_a, 1);
    for (int i = 0; i < 64; i++) bad_pos[i] = (i < 16) ? 1 : 0;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(0, i)); tmp = bad_pos[i]; bad_pos[i] = bad_pos[j]; bad_pos[j] = tmp;
    end
    nbad = 0;
    for (int i = 0; i < 64 && nbad < 16; i++) begin
      if (bad_pos[i] != 0) nbad++;
      h = bad_pos[i] ? bad_hdr() : ok_hdr(); tick(h, h, 1'b1);
      if (nbad < 16) check("win16_hold", lock_a, 1);
    end
    check("win16_unlock", lock_a, 0);
    check("win16_slip", slip_a, 1);
    check("win16_cnt", cnt_a, 1);
    for (int i = 0; i < 16; i++) begin h = 2'($urandom_range(0, 3)); tick(h, h, 1'b1); end
    run_valid(64);
    check("win16_relock", lock_a, 1);

    // Qualified-only evaluation: gaps carrying 2'b00 must be invisible
    do_reset();
    for (int i = 0; i < 30; i++) begin h = ok_hdr(); tick(h, h, 1'b1); end
    for (int i = 0; i < 5; i++) begin
      tick(ok_hdr(), 2'b00, 1'b0);
      check("gap_no_slip", slip_b, 0);
      check("gap_no_inv", inv_b, 0);
    end
    for (int i = 0; i < 33; i++) begin h = ok_hdr(); tick(h, h, 1'b1); end
    check("gbx_lock_63", lock_b, 0);
    tick(ok_hdr(), ok_hdr(), 1'b1);
    check("gbx_lock_64", lock_b, 1);

    // Random traffic with sparse bad headers and random qualifier gaps
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      h = ($urandom_range(0, 15) == 0) ? bad_hdr() : ok_hdr();
      tick(h, ($urandom_range(0, 15) == 0) ? bad_hdr() : ok_hdr(),
           1'($urandom_range(0, 3) != 0));
    end

    // Reset while locked with three unlocks recorded, and during a slip pulse
    do_reset();
    for (int i = 0; i < 3; i++) unlock_loop();
    run_valid(64);
    check("pre_rst_cnt", cnt_a, 3);
    check("pre_rst_lock", lock_a, 1);
    rst = 1'b1;
    tick(ok_hdr(), ok_hdr(), 1'b1);
    rst = 1'b0;
    check("rst_mid_lock", lock_a, 0);
    check("rst_mid_cnt", cnt_a, 0);
    check("rst_mid_slip", slip_a, 0);
    run_valid(64);
    check("rst_relock", lock_a, 1);
    for (int i = 0; i < 16; i++) begin h = bad_hdr(); tick(h, h, 1'b1); end
    check("slip_before_rst", slip_a, 1);
    rst = 1'b1;
    tick(2'b00, 2'b00, 1'b1);
    rst = 1'b0;
    check("rst_in_slip", slip_a, 0);
    check("rst_in_slip_cnt", cnt_a, 0);

    // Saturation of the unlock counter
    for (int i = 0; i < 300; i++) unlock_loop();
    check("sat_cnt_a", cnt_a, 255);
    check("sat_cnt_b", cnt_b, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_baser_rx_block_lock.md
Name: taxi_baser_rx_block_lock

Overview:
- 10GBASE-R receive block-lock stage, after the SERDES/gearbox and before the descrambler and XGMII decoder.
- Examines each 2-bit sync header and runs the block-lock state machine (IEEE 802.3 cl. 49.2.13.2.2 semantics).
- Drives the SERDES bitslip request until header alignment is found.
- Reports lock status and header-error pulses so downstream stages can qualify decoded blocks.

Parameters:
- HDR_W, 2, sync header width; only 2 is legal (elaboration $fatal otherwise).
- GBX_IF_EN, 1'b0, when 1, only cycles with encoded_rx_hdr_valid=1 are evaluated; when 0, every cycle is evaluated.
- SH_CNT_MAX, 64, headers per test window; legal 4..1024.
- SH_INV_MAX, 16, invalid headers in one window that force loss of lock; legal 1..SH_CNT_MAX.
- SLIP_WAIT, 16, evaluated header slots ignored after a bitslip; legal 1..255.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- encoded_rx_hdr, input, HDR_W, sync header from SERDES/gearbox.
- encoded_rx_hdr_valid, input, 1, header qualifier; ignored when GBX_IF_EN=0.
- rx_block_lock, output, 1, block lock status, registered.
- serdes_rx_bitslip, output, 1, single-cycle slip request to SERDES.
- rx_sh_invalid, output, 1, single-cycle pulse per evaluated invalid header (2'b00 or 2'b11).
- rx_unlock_count, output, 8, saturating count of lock-to-unlock transitions.

Behaviour:
- Evaluated slot: a cycle where GBX_IF_EN=0, or encoded_rx_hdr_valid=1. Non-evaluated cycles change no state and drive serdes_rx_bitslip=0 and rx_sh_invalid=0.
- Valid header: encoded_rx_hdr[1]^encoded_rx_hdr[0].
- Counters:
  - sh_cnt: 0..SH_CNT_MAX, width $clog2(SH_CNT_MAX+1).
  - sh_inv_cnt: 0..SH_INV_MAX.
  - slip_cnt: 0..SLIP_WAIT.
  - Each evaluated slot increments a counter by at most 1.
- Reset: rx_block_lock=0, serdes_rx_bitslip=0, rx_sh_invalid=0, rx_unlock_count=0, all counters 0, state TEST_SH.
- All outputs are registered. A response to slot N appears on the clock edge that samples slot N, i.e. visible the cycle after the header is presented.
- TEST_SH, unlocked, per evaluated slot:
  - Invalid header: pulse serdes_rx_bitslip, clear sh_cnt, load slip_cnt=SLIP_WAIT, go to SLIP_WAIT.
  - Valid header: sh_cnt+1. When that makes sh_cnt=SH_CNT_MAX, set rx_block_lock=1, clear both counters, go to LOCKED.
- SLIP_WAIT, per evaluated slot:
  - slip_cnt-1, headers ignored; rx_sh_invalid still pulses on invalid headers.
  - When slip_cnt reaches 0, go to TEST_SH with counters cleared.
  - No further bitslip is issued in this state.
- LOCKED, per evaluated slot:
  - sh_cnt+1; on an invalid header also sh_inv_cnt+1.
  - If sh_inv_cnt reaches SH_INV_MAX (counting the current header): rx_block_lock=0, pulse serdes_rx_bitslip, increment rx_unlock_count (saturates at 255), clear counters, load slip_cnt, go to SLIP_WAIT. This takes priority over window end.
  - Else if sh_cnt reaches SH_CNT_MAX: clear both counters and stay LOCKED (new window).
- serdes_rx_bitslip is never high on two consecutive cycles.
- rst asserted mid-operation (including during SLIP_WAIT or a bitslip pulse) returns everything to reset values on the next edge.

Decomposition:
- Shared package taxi_baser_pkg holds:
  - SYNC_DATA=2'b10 and SYNC_CTRL=2'b01 (shared with the encoder/decoder).
  - The lock-state enum {TEST_SH, SLIP_WAIT, LOCKED}.
- No sub-module; a single FSM with three counters.

Test Plan:
- Reset, then 64 consecutive 2'b01/2'b10 headers -> rx_block_lock=0 after the 63rd, =1 the cycle after the 64th; no bitslip.
- Unlocked, header 2'b00 in slot 10 -> rx_sh_invalid and serdes_rx_bitslip each high for exactly 1 cycle. The next 16 slots, even if all 2'b11, produce no bitslip. Lock asserts after 64 further valid headers.
- Locked, 15 invalid headers spread over a 64-slot window -> lock held, window restarts. A following window with 16 invalid -> lock=0 and bitslip pulse the cycle after the 16th invalid; rx_unlock_count=1.
- GBX_IF_EN=1, hdr_valid=0 with header 2'b00 for 5 cycles mid-test -> no bitslip, no rx_sh_invalid, sh_cnt unchanged. Lock asserts after exactly 64 qualified headers.
- Locked with rx_unlock_count=3, rst pulsed 1 cycle -> next cycle lock=0, count=0, bitslip=0. Lock is then reacquired after 64 valid headers.
- Force 300 lock/unlock cycles -> rx_unlock_count stops at 255.
